// File: rtl/seg7_pkg.sv
// Shared glyph constants (active-high, bit6..bit0 = g..a) and capture FSM state type.
package seg7_pkg;
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic {SETTLE, STABLE} capture_state_t;
endpackage

// File: rtl/sevenseg_capture_if.sv
// Decoded-frame bus with valid/ack handshake between the capture block and its consumer.
interface sevenseg_capture_if;
    logic [3:0] BCD0, BCD1, BCD2, BCD3, BCD4, BCD5, BCD6, BCD7;
    logic [7:0] blank;
    logic [7:0] bad;
    logic       frame_valid;
    logic       frame_ack;
    logic       overrun;

    modport master (
        output BCD0, BCD1, BCD2, BCD3, BCD4, BCD5, BCD6, BCD7,
        output blank, bad, frame_valid, overrun,
        input  frame_ack
    );
    modport slave (
        input  BCD0, BCD1, BCD2, BCD3, BCD4, BCD5, BCD6, BCD7,
        input  blank, bad, frame_valid, overrun,
        output frame_ack
    );
endinterface

// File: rtl/seg7_digit_decode.sv
// Combinational decode of one active-low seven-segment digit into BCD/blank/bad.
// SEVENSEG_CAPTURE_HEX_EN additionally accepts the A..F letter glyphs as 10..15.
module seg7_digit_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic [3:0] bcd,
    output logic       blank,
    output logic       bad
);
    logic [6:0] pat;

    always_comb begin
        pat   = ~seg_n;
        bcd   = 4'h0;
        blank = 1'b0;
        bad   = 1'b0;
        case (pat)
            SEG_BLANK: blank = 1'b1;
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
`ifdef SEVENSEG_CAPTURE_HEX_EN
            SEG_A:     bcd = 4'd10;
            SEG_B:     bcd = 4'd11;
            SEG_C:     bcd = 4'd12;
            SEG_D:     bcd = 4'd13;
            SEG_E:     bcd = 4'd14;
            SEG_F:     bcd = 4'd15;
`endif
            default: begin
                bad = 1'b1;
                bcd = 4'hF;
            end
        endcase
    end
endmodule

// File: rtl/sevenseg_capture.sv
// Synchronises and debounces eight HEX segment buses and delivers decoded frames
// over a valid/ack handshake. Letter decode is enabled by SEVENSEG_CAPTURE_HEX_EN.
module sevenseg_capture
    import seg7_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset_L,
    input  logic [6:0] HEX0,
    input  logic [6:0] HEX1,
    input  logic [6:0] HEX2,
    input  logic [6:0] HEX3,
    input  logic [6:0] HEX4,
    input  logic [6:0] HEX5,
    input  logic [6:0] HEX6,
    input  logic [6:0] HEX7,
    sevenseg_capture_if.master bus
);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [55:0] ALL_OFF = {8{7'h7F}};

    logic [55:0]     hex_all;
    logic [55:0]     sync_q [SYNC_STAGES];
    logic [55:0]     sync_d [SYNC_STAGES];
    logic [55:0]     s;
    logic [55:0]     s_prev_q, s_prev_d;
    logic [55:0]     deliv_q, deliv_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    capture_state_t  state_q, state_d;
    logic            changed, commit, new_frame;

    logic [7:0][3:0] dec_bcd, bcd_q, bcd_d;
    logic [7:0]      dec_blank, blank_q, blank_d;
    logic [7:0]      dec_bad, bad_q, bad_d;
    logic            fv_q, fv_d, ovr_q, ovr_d;

    assign hex_all = {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
    assign s       = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d[0] = hex_all;
        for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_dec
            seg7_digit_decode u_dec (
                .seg_n (s[7*gi +: 7]),
                .bcd   (dec_bcd[gi]),
                .blank (dec_blank[gi]),
                .bad   (dec_bad[gi])
            );
        end
    endgenerate

    // FSM: state register
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) state_q <= SETTLE;
        else          state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        changed = (s != s_prev_q);
        commit  = (state_q == SETTLE) && !changed && (cnt_q == CNT_LAST);
        state_d = state_q;
        if (changed)     state_d = SETTLE;
        else if (commit) state_d = STABLE;
    end

    // FSM outputs and datapath next values
    always_comb begin
        s_prev_d  = s;
        cnt_d     = cnt_q;
        if (changed)                   cnt_d = '0;
        else if (state_q == SETTLE && !commit) cnt_d = cnt_q + CNT_W'(1);
        // A frame identical to the last delivered one is swallowed silently.
        new_frame = commit && (s != deliv_q);
        deliv_d   = commit ? s : deliv_q;
        bcd_d     = new_frame ? dec_bcd   : bcd_q;
        blank_d   = new_frame ? dec_blank : blank_q;
        bad_d     = new_frame ? dec_bad   : bad_q;
        fv_d      = fv_q;
        if (new_frame)                  fv_d = 1'b1;
        else if (fv_q && bus.frame_ack) fv_d = 1'b0;
        ovr_d     = ovr_q | (new_frame & fv_q & ~bus.frame_ack);
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= ALL_OFF;
            s_prev_q <= ALL_OFF;
            deliv_q  <= ALL_OFF;
            cnt_q    <= '0;
            bcd_q    <= '0;
            blank_q  <= 8'hFF;
            bad_q    <= 8'h00;
            fv_q     <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= sync_d[k];
            s_prev_q <= s_prev_d;
            deliv_q  <= deliv_d;
            cnt_q    <= cnt_d;
            bcd_q    <= bcd_d;
            blank_q  <= blank_d;
            bad_q    <= bad_d;
            fv_q     <= fv_d;
            ovr_q    <= ovr_d;
        end
    end

    assign bus.BCD0        = bcd_q[0];
    assign bus.BCD1        = bcd_q[1];
    assign bus.BCD2        = bcd_q[2];
    assign bus.BCD3        = bcd_q[3];
    assign bus.BCD4        = bcd_q[4];
    assign bus.BCD5        = bcd_q[5];
    assign bus.BCD6        = bcd_q[6];
    assign bus.BCD7        = bcd_q[7];
    assign bus.blank       = blank_q;
    assign bus.bad         = bad_q;
    assign bus.frame_valid = fv_q;
    assign bus.overrun     = ovr_q;
endmodule

// File: tb/tb_sevenseg_capture.sv
// Directed self-checking bench for sevenseg_capture; honours SEVENSEG_CAPTURE_HEX_EN.
module tb_sevenseg_capture;
    logic       clock = 1'b0;
    logic       reset_L;
    logic [6:0] hex [8];
    int         compared = 0;
    int         mismatched = 0;
    int         n;

    sevenseg_capture_if bus ();

    sevenseg_capture dut (
        .clock   (clock),
        .reset_L (reset_L),
        .HEX0    (hex[0]),
        .HEX1    (hex[1]),
        .HEX2    (hex[2]),
        .HEX3    (hex[3]),
        .HEX4    (hex[4]),
        .HEX5    (hex[5]),
        .HEX6    (hex[6]),
        .HEX7    (hex[7]),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Edges until frame_valid is seen high, bounded by max.
    task automatic wait_fv(input int max, output int edges);
        edges = 0;
        while (bus.frame_valid !== 1'b1 && edges < max) begin
            step();
            edges++;
        end
    endtask

    // Number of cycles frame_valid is high over a window.
    task automatic count_fv(input int cycles, output int highs);
        highs = 0;
        repeat (cycles) begin
            step();
            if (bus.frame_valid === 1'b1) highs++;
        end
    endtask

    task automatic ack_pulse();
        bus.frame_ack = 1'b1;
        step();
        bus.frame_ack = 1'b0;
    endtask

    task automatic all_off();
        for (int i = 0; i < 8; i++) hex[i] = 7'h7F;
    endtask

    initial begin
        reset_L       = 1'b0;
        bus.frame_ack = 1'b0;
        all_off();
        repeat (3) step();
        reset_L = 1'b1;

        count_fv(20, n);
        check("idle_no_frame", n, 0);
        check("idle_blank", bus.blank, 8'hFF);
        check("idle_bcd", {bus.BCD7, bus.BCD6, bus.BCD5, bus.BCD4,
                           bus.BCD3, bus.BCD2, bus.BCD1, bus.BCD0}, 32'h0);
        check("idle_bad", bus.bad, 8'h00);
        check("idle_overrun", bus.overrun, 1'b0);

        hex[0] = ~7'h5B;
        wait_fv(20, n);
        check("latency", n, 7);
        check("d0_bcd", bus.BCD0, 4'd2);
        check("d0_blank", bus.blank, 8'hFE);
        check("d0_bad", bus.bad, 8'h00);
        ack_pulse();
        check("ack_clears", bus.frame_valid, 1'b0);

        for (int i = 0; i < 10; i++) begin
            hex[3] = (i % 2 == 0) ? ~7'h06 : ~7'h07;
            step();
        end
        hex[3] = ~7'h6F;
        begin
            int rises;
            logic prev;
            rises = 0;
            prev  = bus.frame_valid;
            repeat (30) begin
                step();
                if (bus.frame_valid === 1'b1 && prev !== 1'b1) rises++;
                prev = bus.frame_valid;
            end
            check("bounce_one_frame", rises, 1);
        end
        check("d3_bcd", bus.BCD3, 4'd9);
        check("d3_blank", bus.blank, 8'hF6);
        ack_pulse();
        hex[3] = ~7'h06;
        step();
        hex[3] = ~7'h6F;
        count_fv(20, n);
        check("return_no_frame", n, 0);

        hex[5] = ~7'h77;
        wait_fv(20, n);
        check("d5_latency", n, 7);
`ifdef SEVENSEG_CAPTURE_HEX_EN
        check("d5_bcd", bus.BCD5, 4'hA);
        check("d5_bad", bus.bad, 8'h00);
`else
        check("d5_bcd", bus.BCD5, 4'hF);
        check("d5_bad", bus.bad, 8'h20);
`endif

        // Frame pending; next commit coincides with ack.
        hex[6] = ~7'h4F;
        repeat (6) step();
        check("pending_before", bus.frame_valid, 1'b1);
        bus.frame_ack = 1'b1;
        step();
        bus.frame_ack = 1'b0;
        check("same_cycle_fv", bus.frame_valid, 1'b1);
        check("same_cycle_bcd6", bus.BCD6, 4'd3);
        check("same_cycle_ovr", bus.overrun, 1'b0);

        hex[1] = ~7'h66;
        count_fv(10, n);
        check("ovw_fv", bus.frame_valid, 1'b1);
        check("ovw_bcd1", bus.BCD1, 4'd4);
        check("ovw_overrun", bus.overrun, 1'b1);
        ack_pulse();
        check("ovw_ack", bus.frame_valid, 1'b0);
        ack_pulse();
        check("ack_ignored", bus.frame_valid, 1'b0);
        check("ovr_sticky", bus.overrun, 1'b1);

        hex[2] = ~7'h7D;
        repeat (4) step();
        reset_L = 1'b0;
        #1;
        check("rst1_fv", bus.frame_valid, 1'b0);
        check("rst1_blank", bus.blank, 8'hFF);
        check("rst1_bcd", {bus.BCD7, bus.BCD6, bus.BCD5, bus.BCD4,
                           bus.BCD3, bus.BCD2, bus.BCD1, bus.BCD0}, 32'h0);
        check("rst1_bad", bus.bad, 8'h00);
        check("rst1_ovr", bus.overrun, 1'b0);
        all_off();
        repeat (3) step();
        reset_L = 1'b1;
        count_fv(20, n);
        check("rst1_no_stale", n, 0);

        hex[7] = ~7'h3F;
        wait_fv(20, n);
        check("d7_latency", n, 7);
        check("d7_bcd", bus.BCD7, 4'd0);
        check("d7_blank", bus.blank, 8'h7F);
        reset_L = 1'b0;
        #1;
        check("rst2_fv", bus.frame_valid, 1'b0);
        check("rst2_blank", bus.blank, 8'hFF);
        all_off();
        repeat (3) step();
        reset_L = 1'b1;
        count_fv(20, n);
        check("rst2_no_stale", n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/sevenseg_capture.md
Name: sevenseg_capture

Overview:
- Reverse of the BCD-to-seven-segment driver: monitors the eight active-low HEX7..HEX0 segment buses and recovers per-digit BCD, blank and invalid-pattern flags.
- Inputs are synchronised and debounced. A new stable frame is delivered through a valid/ack handshake.
- Used as an on-board self-check and scoreboard tap, so displayed values can be read back by a checker or a host interface.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on every HEX input bit (minimum 2).
- STABLE_CYCLES, 4, consecutive unchanged synchronised samples needed before a frame is committed (minimum 1).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- HEX7..HEX0  input  7 each  active-low segments, bit6..bit0 = g..a.
- BCD7..BCD0  output  4 each  decoded digit value.
- blank  output  8  bit i = digit i shows all segments off.
- bad  output  8  bit i = digit i pattern is not a legal glyph.
- frame_valid  output  1  committed frame held on BCD/blank/bad.
- frame_ack  input  1  consumer accepts the frame.
- overrun  output  1  sticky: a frame was overwritten before being acked.

Behaviour:
- Reset (asynchronous on reset_L low):
  - Synchroniser flops, s_prev and delivered-frame register load 7'h7F per digit (all segments off).
  - cnt = 0; state = SETTLE.
  - Outputs: BCD* = 0, blank = 8'hFF, bad = 0, frame_valid = 0, overrun = 0.
- Synchroniser: a 56-bit bus s passes through SYNC_STAGES flops.
- Change detect:
  - If s != s_prev: s_prev <= s, cnt <= 0, state <= SETTLE.
  - Otherwise, in SETTLE, cnt increments.
- Commit:
  - Occurs in SETTLE when cnt == STABLE_CYCLES-1 and s == s_prev. State then goes to STABLE.
  - STABLE holds until s changes.
  - The commit loads outputs only if s differs from the delivered-frame register. That register then takes s.
  - A bounce back to the already delivered frame produces no new frame.
- Latency: an input change held steady gives frame_valid high exactly SYNC_STAGES+1+STABLE_CYCLES rising edges later (7 at defaults).
- Per-digit decode of ~HEX:
  - 7'h00 -> blank = 1, BCD = 0, bad = 0.
  - 0x3F,06,5B,4F,66,6D,7D,07,7F,6F -> BCD 0..9, blank = 0, bad = 0.
  - Any other pattern -> bad = 1, BCD = 4'hF, blank = 0.
- Handshake:
  - frame_valid rises on commit and stays high until a cycle with frame_valid & frame_ack. It is low on the following cycle unless a commit occurs in that same cycle.
  - Commit and ack in the same cycle: the new frame loads and frame_valid stays 1; overrun is not set.
  - Commit while frame_valid = 1 without ack: outputs overwrite, frame_valid stays 1, overrun <= 1.
  - overrun clears only on reset.
  - frame_ack while frame_valid = 0 is ignored.
- Outputs are registered and stable while frame_valid = 1, except on overwrite.
- Reset mid-debounce: the pending count is discarded. A frame already valid is dropped (frame_valid = 0).

Optional Feature:
- Macro SEVENSEG_CAPTURE_HEX_EN.
- Defined: the letter glyphs A 0x77, b 0x7C, C 0x39, d 0x5E, E 0x79, F 0x71 decode to BCD 10..15 with bad = 0.
- Undefined: those glyphs flag bad = 1, BCD = 4'hF.
- 7'h7F -> 8 in both builds.

Decomposition:
- Package seg7_pkg:
  - SEG_* glyph constants for 0..9 and A..F, active-high g..a.
  - SEG_BLANK = 7'h00.
  - Enum capture_state_t {SETTLE, STABLE}.
- Sub-module seg7_digit_decode, instantiated 8 times:
  - Combinational; input active-low segments.
  - Outputs bcd[3:0], blank, bad.
  - Honours the macro.

Test Plan:
- Reset with HEX* = 7'h7F held for 20 cycles -> frame_valid stays 0; blank = 8'hFF, BCD* = 0.
- HEX0 = ~7'h5B, others 7'h7F, frame_ack = 0 -> frame_valid high exactly 7 edges later; BCD0 = 2, blank = 8'hFE, bad = 0. Pulse ack -> frame_valid low next cycle.
- HEX3 toggles each cycle for 10 cycles, then settles to ~7'h6F -> exactly one commit, with BCD3 = 9. HEX3 returning to the same value produces no extra frame.
- HEX5 = ~7'h77 -> without macro: bad = 8'h20, BCD5 = 4'hF. With macro: BCD5 = 10, bad = 0.
- Two stable frames committed with no ack between -> second frame on outputs, frame_valid = 1, overrun = 1. Ack in the same cycle as a commit -> overrun stays 0.
- reset_L asserted mid-SETTLE and again while frame_valid = 1 -> all outputs return to reset values asynchronously; no stale commit after release.
